inst_mem_write_buffer: RTL and testbench
========================================

Name: inst_mem_write_buffer

Overview:
- Sits directly downstream of the instruction-memory write stage and upstream of the single-port instruction RAM.
- Queues instruction-memory writes (address, data) issued by the op 001010 store path.
- Drains the queue into the RAM only on cycles when instruction fetch is not using the port.
- Forwards pending data to fetch so self-modifying code reads the newest value before it reaches RAM.

Parameters:
DEPTH, 4, number of buffered writes; power of two, at least 2
ADDR_W, 16, instruction-memory word address width
DATA_W, 32, instruction word width

Ports:
clk  in  1  single system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
write_enable  in  1  write request from the upstream writer stage, one write per cycle
address  in  ADDR_W  write address, valid with write_enable
write_data  in  DATA_W  write data, valid with write_enable
fetch_req  in  1  fetch owns the RAM port this cycle; drain is inhibited
fetch_addr  in  ADDR_W  address currently being fetched
almost_full  out  1  combinational, count >= DEPTH-1; pipeline stall request
full  out  1  combinational, count == DEPTH
empty  out  1  combinational, count == 0
count  out  clog2(DEPTH)+1  number of valid entries
overflow  out  1  sticky; set when a write arrives while full
fwd_hit  out  1  combinational; a pending or in-flight write matches fetch_addr
fwd_data  out  DATA_W  combinational; data of the highest-priority match, 0 when no hit
mem_we  out  1  registered RAM write enable
mem_addr  out  ADDR_W  registered RAM write address
mem_wdata  out  DATA_W  registered RAM write data

Behaviour:
- Reset (synchronous, takes priority over all other activity):
  - count, head pointer, tail pointer: 0.
  - mem_we, mem_addr, mem_wdata: 0.
  - overflow: 0.
  - Reset mid-operation discards all pending entries; no RAM write is issued for them.
- Storage: circular array of DEPTH entries {addr, data}.
  - Pointers increment modulo DEPTH; wrap-around is seamless.
- Enqueue, evaluated at each edge:
  - Condition: write_enable=1 and (count<DEPTH, or a pop happens in the same edge).
  - Action: write to slot tail, then tail+1.
  - If write_enable=1, count==DEPTH and there is no pop: the write is dropped and overflow is set.
  - overflow stays set until reset.
  - Upstream must stall on almost_full, because the writer stage has one cycle of registered lag.
- Pop / drain, evaluated at each edge:
  - Condition: count>0 and fetch_req=0.
  - Action: mem_we<=1, mem_addr<=entry[head].addr, mem_wdata<=entry[head].data, head+1.
  - Otherwise mem_we<=0, and mem_addr/mem_wdata hold their previous values.
- Count update: push only is +1; pop only is -1; push and pop together leave count unchanged.
- Latency and ordering:
  - A write enqueued at edge N into an empty buffer, with fetch_req=0 at edge N+1, drives mem_we=1 during the cycle after edge N+1.
  - RAM writes occur in strict FIFO order.
- Fetch contention:
  - fetch_req=1 blocks draining indefinitely; entries are held and enqueue continues until full.
- Forwarding (combinational):
  - Compare fetch_addr against every valid entry and against the in-flight register (mem_we=1, mem_addr).
  - Priority: youngest valid entry first, then older entries, then the in-flight register.
  - A write arriving on the input ports in the current cycle is not forwarded until it has been enqueued.
  - Duplicate addresses in the queue are legal; the youngest wins.
- The empty, full, almost_full and count outputs reflect the current registered count only.

Test Plan:
- Reset, then a single write (address=0x0010, data=0xDEADBEEF) with fetch_req=0: count goes 0 -> 1 -> 0; mem_we is high for exactly one cycle with mem_addr=0x0010 and mem_wdata=0xDEADBEEF, two edges after write_enable.
- fetch_req=1 held, five consecutive writes to addresses 1..5 with DEPTH=4:
  - almost_full rises after the 3rd write and full after the 4th.
  - The 5th write is dropped and overflow=1.
  - After fetch_req drops, the RAM receives addresses 1,2,3,4 in order; address 5 is never written.
- fetch_req=1, queue writes 0x0020<-0x11111111 then 0x0020<-0x22222222, set fetch_addr=0x0020: fwd_hit=1 and fwd_data=0x22222222; fetch_addr=0x0021 gives fwd_hit=0 and fwd_data=0.
- With count=DEPTH and fetch_req=0, write_enable=1 in the same cycle: the pop and push both occur, count stays at DEPTH, overflow stays 0.
- Stream 10 writes to consecutive addresses with fetch_req toggling every cycle, pointers wrapping at least twice: the RAM receives all 10 writes in order with correct data, overflow=0, and the buffer ends empty.
- Three entries pending with fetch_req=1, reset asserted for one cycle: count=0, mem_we=0, overflow=0, and no RAM write follows after fetch_req drops.

Source files
------------

// File: rtl/inst_mem_write_buffer.sv
// Instruction-memory write buffer: queues store-path writes and drains them into the
// single-port instruction RAM on fetch-idle cycles, forwarding pending data to fetch.
module inst_mem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       write_enable,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       fetch_req,
    input  logic [ADDR_W-1:0]          fetch_addr,
    output logic                       almost_full,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              push;
    logic              pop;

    // A pop on the same edge frees a slot, so a full buffer can still accept a write.
    assign pop  = (count != '0) && !fetch_req;
    assign push = write_enable && ((count != CNT_W'(DEPTH)) || pop);

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count >= CNT_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            entries[tail] <= '{addr: address, data: write_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                mem_we    <= 1'b1;
                mem_addr  <= entries[head].addr;
                mem_wdata <= entries[head].data;
                head      <= head + 1'b1;
            end else begin
                mem_we    <= 1'b0;
            end
            if (write_enable && !push) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Walk from oldest to youngest so later matches override; in-flight is lowest priority.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (mem_we && (mem_addr == fetch_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_wdata;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].addr == fetch_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx].data;
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_write_buffer.sv
// Directed self-checking bench for inst_mem_write_buffer (DEPTH=4).
module tb_inst_mem_write_buffer;
    logic        clk = 1'b0;
    logic        reset, write_enable, fetch_req;
    logic [15:0] address, fetch_addr;
    logic [31:0] write_data;
    logic        almost_full, full, empty, overflow, fwd_hit, mem_we;
    logic [2:0]  count;
    logic [31:0] fwd_data, mem_wdata;
    logic [15:0] mem_addr;

    int tests = 0;
    int fails = 0;

    inst_mem_write_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .write_enable(write_enable), .address(address),
        .write_data(write_data), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .almost_full(almost_full), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        write_enable = 1'b1;
        address      = a;
        write_data   = d;
    endtask

    logic [15:0] exp_a[$];
    logic [31:0] exp_d[$];
    int          seen;
    int          issued;
    int          cyc;

    initial begin
        reset = 1'b1; write_enable = 1'b0; fetch_req = 1'b0;
        address = '0; write_data = '0; fetch_addr = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_overflow", overflow, 0);

        // Single write, two-edge latency to RAM
        wr(16'h0010, 32'hDEADBEEF);
        step();
        write_enable = 1'b0;
        chk("t1_count1", count, 1);
        chk("t1_we_early", mem_we, 0);
        step();
        chk("t1_count0", count, 0);
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 16'h0010);
        chk("t1_data", mem_wdata, 32'hDEADBEEF);
        fetch_addr = 16'h0010;
        #1;
        chk("t1_fwd_inflight_hit", fwd_hit, 1);
        chk("t1_fwd_inflight_data", fwd_data, 32'hDEADBEEF);
        step();
        chk("t1_we_off", mem_we, 0);
        chk("t1_addr_hold", mem_addr, 16'h0010);

        // Fill under fetch contention, overflow on the 5th write
        fetch_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wr(16'(i), 32'h100 + 32'(i));
            step();
            if (i == 2) chk("t2_af_after2", almost_full, 0);
            if (i == 3) begin
                chk("t2_af_after3", almost_full, 1);
                chk("t2_full_after3", full, 0);
            end
            if (i == 4) begin
                chk("t2_full_after4", full, 1);
                chk("t2_ovf_after4", overflow, 0);
            end
        end
        write_enable = 1'b0;
        chk("t2_count", count, 4);
        chk("t2_overflow", overflow, 1);
        fetch_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t2_drain_we", mem_we, 1);
            chk("t2_drain_addr", mem_addr, 16'(i));
            chk("t2_drain_data", mem_wdata, 32'h100 + 32'(i));
        end
        step();
        chk("t2_no5th", mem_we, 0);
        chk("t2_empty", empty, 1);
        chk("t2_ovf_sticky", overflow, 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t2_ovf_clear", overflow, 0);

        // Forwarding: youngest duplicate wins; same-cycle input not forwarded
        fetch_req = 1'b1;
        wr(16'h0020, 32'h11111111); step();
        wr(16'h0020, 32'h22222222); step();
        write_enable = 1'b0;
        fetch_addr = 16'h0020; #1;
        chk("t3_hit", fwd_hit, 1);
        chk("t3_data", fwd_data, 32'h22222222);
        fetch_addr = 16'h0021; #1;
        chk("t3_miss_hit", fwd_hit, 0);
        chk("t3_miss_data", fwd_data, 0);
        wr(16'h0021, 32'h33333333); #1;
        chk("t3_input_not_fwd", fwd_hit, 0);
        step();
        chk("t3_enq_hit", fwd_hit, 1);
        chk("t3_enq_data", fwd_data, 32'h33333333);

        // Simultaneous push and pop while full
        wr(16'h0022, 32'h44444444); step();
        chk("t4_full", full, 1);
        wr(16'h0030, 32'h55555555);
        fetch_req = 1'b0;
        step();
        write_enable = 1'b0;
        chk("t4_count", count, 4);
        chk("t4_overflow", overflow, 0);
        chk("t4_we", mem_we, 1);
        chk("t4_addr", mem_addr, 16'h0020);
        chk("t4_data", mem_wdata, 32'h11111111);
        step(); chk("t4_d2", mem_wdata, 32'h22222222);
        step(); chk("t4_d3", mem_addr, 16'h0021);
        step(); chk("t4_d4", mem_addr, 16'h0022);
        step();
        chk("t4_d5_addr", mem_addr, 16'h0030);
        chk("t4_d5_data", mem_wdata, 32'h55555555);
        chk("t4_empty", empty, 1);

        // Stream 10 writes with fetch_req toggling, writer stalling on almost_full
        issued = 0; seen = 0; cyc = 0;
        while ((issued < 10 || seen < 10) && cyc < 200) begin
            fetch_req = cyc[0];
            if (issued < 10 && !almost_full) begin
                wr(16'h0040 + 16'(issued), 32'hA0000000 + 32'(issued));
                exp_a.push_back(16'h0040 + 16'(issued));
                exp_d.push_back(32'hA0000000 + 32'(issued));
                issued++;
            end else begin
                write_enable = 1'b0;
            end
            step();
            cyc++;
            if (mem_we) begin
                if (exp_a.size() == 0) begin
                    chk("t5_unexpected_write", 1, 0);
                end else begin
                    chk("t5_addr", mem_addr, exp_a.pop_front());
                    chk("t5_data", mem_wdata, exp_d.pop_front());
                end
                seen++;
            end
        end
        write_enable = 1'b0;
        fetch_req = 1'b0;
        chk("t5_timeout", (cyc < 200), 1);
        chk("t5_seen", seen, 10);
        chk("t5_overflow", overflow, 0);
        step();
        chk("t5_empty", empty, 1);

        // Reset mid-operation discards pending entries
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr(16'h0060 + 16'(i), 32'hB0 + 32'(i)); step();
        end
        write_enable = 1'b0;
        chk("t6_count3", count, 3);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_count", count, 0);
        chk("t6_we", mem_we, 0);
        chk("t6_overflow", overflow, 0);
        fetch_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_write", mem_we, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
